inst_fetch_unit: RTL and testbench

Fetch stage of the RV32I multicycle core; sits directly upstream of the instruction decoder.
- Owns the PC and PC-of-current-instruction registers.
- Issues one request/response read to instruction memory per fetch command from the control FSM.
- Latches the returned word into the instruction register that drives the decoder's I_Reg input.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/inst_fetch_unit_if.sv | 23 ++
 rtl/fetch_pc_reg.sv | 54 +++++
 rtl/inst_fetch_unit.sv | 91 +++++++++
 tb/tb_inst_fetch_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface inst_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// PC / PC-of-current-instruction registers with load, advance and alignment handling.
// FETCH_MISALIGN_TRAP_EN: keep misaligned load targets and flag them instead of truncating.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        advance,
  output logic [31:0] pc,
  output logic [31:0] pc_old,
  output logic        misalign_err,
  output logic        misalign_next
);

  logic [31:0] load_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  // The flag the FSM must see for a fetch issued in the same cycle as a load.
  assign misalign_next = load ? (load_value[1:0] != 2'b00) : misalign_err;
  assign load_target   = load_value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misalign_next;
    end
  end
`else
  logic unused_low_bits;

  assign unused_low_bits = ^load_value[1:0];
  assign load_target     = {load_value[31:2], 2'b00};
  assign misalign_next   = 1'b0;
  assign misalign_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      pc_old <= RESET_PC;
    end else if (load) begin
      pc <= load_target;
    end else if (advance) begin
      pc_old <= pc;
      pc     <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: one memory read per fetch command, result latched into I_Reg.
// FETCH_MISALIGN_TRAP_EN: a misaligned PC skips the memory read and completes at once.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_start,
  input  logic                      pc_load,
  input  logic [31:0]               pc_next,
  inst_fetch_unit_if.master         imem,
  output logic [31:0]               I_Reg,
  output logic [31:0]               pc,
  output logic [31:0]               pc_old,
  output logic                      fetch_done,
  output logic                      busy,
  output logic                      misalign_err
);

  fetch_state_t state, state_nxt;
  logic         load_en;
  logic         advance_en;
  logic         misalign_next;

  assign load_en    = (state == IDLE) && pc_load;
  assign advance_en = (state == WAIT) && imem.imem_rvalid;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .load          (load_en),
    .load_value    (pc_next),
    .advance       (advance_en),
    .pc            (pc),
    .pc_old        (pc_old),
    .misalign_err  (misalign_err),
    .misalign_next (misalign_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    imem.imem_req = 1'b0;
    fetch_done    = 1'b0;
    busy          = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (fetch_start) begin
          state_nxt = misalign_next ? DONE : REQ;
        end
      end
      REQ: begin
        imem.imem_req = 1'b1;
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        fetch_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imem.imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      I_Reg <= NOP_INSTR;
    end else if (advance_en) begin
      I_Reg <= imem.imem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed fetches, checked by a negedge monitor.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_start = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_next = '0;
  logic [31:0] I_Reg, pc, pc_old;
  logic        fetch_done, busy, misalign_err;

  inst_fetch_unit_if ifc ();

  inst_fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_start  (fetch_start),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .imem         (ifc.master),
    .I_Reg        (I_Reg),
    .pc           (pc),
    .pc_old       (pc_old),
    .fetch_done   (fetch_done),
    .busy         (busy),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] old;
  } done_t;

  logic [31:0] req_q[$];
  done_t       done_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_ir = 32'h0000_0013;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every request and every completion must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.imem_req) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          chk("req_addr", ifc.imem_addr, req_q.pop_front());
        end
      end
      if (fetch_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          done_t e;
          e = done_q.pop_front();
          chk("done_ireg", I_Reg, e.ir);
          chk("done_pc", pc, e.pc);
          chk("done_pc_old", pc_old, e.old);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_ir = 32'h0000_0013;
  endtask

  task automatic do_load(input logic [31:0] val);
    @(posedge clk); #1;
    pc_load = 1'b1;
    pc_next = val;
    @(posedge clk); #1;
    pc_load = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] data, input int stall,
                          input logic ld, input logic [31:0] ld_val, input logic ld_in_wait,
                          input logic [31:0] e_addr, input logic [31:0] e_pc,
                          input logic [31:0] e_old, input logic no_mem);
    done_t d;
    int    n;
    @(posedge clk); #1;
    fetch_start = 1'b1;
    pc_load     = ld;
    pc_next     = ld_val;
    if (!no_mem) req_q.push_back(e_addr);
    d.ir  = no_mem ? model_ir : data;
    d.pc  = e_pc;
    d.old = e_old;
    done_q.push_back(d);
    @(posedge clk); #1;
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    if (no_mem) begin
      chk("skip_done_cycle1", {31'd0, fetch_done}, 32'd1);
      chk("skip_no_req", {31'd0, ifc.imem_req}, 32'd0);
      @(posedge clk); #1;
      return;
    end
    n = 1;
    while (!ifc.imem_req && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_latency", n, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < stall; i++) begin
      if (ld_in_wait) begin
        pc_load = 1'b1;
        pc_next = 32'h0000_0200;
      end
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_ireg_hold", I_Reg, model_ir);
      @(posedge clk); #1;
    end
    pc_load            = 1'b0;
    ifc.imem_rvalid    = 1'b1;
    ifc.imem_rdata     = data;
    @(posedge clk); #1;
    ifc.imem_rvalid = 1'b0;
    chk("done_latency", {31'd0, fetch_done}, 32'd1);
    model_ir = data;
    @(posedge clk); #1;
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.imem_rvalid = 1'b0;
    ifc.imem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ireg", I_Reg, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_old", pc_old, 32'h0);
    chk("rst_flags", {28'd0, ifc.imem_req, fetch_done, busy, misalign_err}, 32'h0);
    rst = 1'b0;

    // Reset during WAIT aborts the fetch; the late response is dropped.
    do_load(32'h0000_0010);
    @(posedge clk); #1;
    fetch_start = 1'b1;
    req_q.push_back(32'h0000_0010);
    @(posedge clk); #1;
    fetch_start = 1'b0;
    @(posedge clk); #1;
    chk("wait_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_ireg", I_Reg, 32'h0000_0013);
    chk("abort_pc", pc, 32'h0);
    chk("abort_pc_old", pc_old, 32'h0);
    chk("abort_flags", {28'd0, ifc.imem_req, fetch_done, busy, misalign_err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    ifc.imem_rvalid = 1'b0;
    chk("stale_ireg", I_Reg, 32'h0000_0013);
    chk("stale_flags", {30'd0, fetch_done, busy}, 32'h0);
    @(posedge clk); #1;
    chk("stale_pc", pc, 32'h0);

    // Zero-wait fetch from reset PC.
    do_reset();
    do_fetch(32'h0050_0093, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 32'h0, 1'b0);
    // Three-cycle stall.
    do_fetch(32'h00A0_0113, 3, 1'b0, 32'h0, 1'b0, 32'h4, 32'h8, 32'h4, 1'b0);
    // Load and fetch in the same cycle; a load during WAIT is ignored.
    do_fetch(32'h0000_0297, 2, 1'b1, 32'h0000_0100, 1'b1, 32'h100, 32'h104, 32'h100, 1'b0);
    chk("wait_load_ignored", pc, 32'h0000_0104);
    // PC wraparound.
    do_load(32'hFFFF_FFFC);
    do_fetch(32'h0000_006F, 1, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b0);

    do_load(32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag_set", {31'd0, misalign_err}, 32'd1);
    chk("mis_pc", pc, 32'h0000_0102);
    do_fetch(32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0102, 32'hFFFF_FFFC, 1'b1);
    do_load(32'h0000_0104);
    chk("mis_flag_clear", {31'd0, misalign_err}, 32'd0);
    chk("mis_pc_aligned", pc, 32'h0000_0104);
`else
    chk("align_pc", pc, 32'h0000_0100);
    chk("align_flag", {31'd0, misalign_err}, 32'd0);
    do_fetch(32'h0000_0013, 0, 1'b0, 32'h0, 1'b0, 32'h100, 32'h104, 32'h100, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("done_q_drained", done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
